ysyx_25030077_rd_arbiter: RTL and testbench

- Shares the single memory read channel (AR + R, AXI4-lite subset) between two requesters: m0 = IFU instruction fetch, m1 = LSU load.
- Accepts one address request at a time and forwards it to the slave.
- Routes the returned R beat back to the originating master.
- Sits between the IFU/LSU and the memory/xbar read port; strictly one outstanding transaction.

---
 rtl/ysyx_25030077_bus_pkg.sv | 21 ++
 rtl/ysyx_25030077_arb2.sv | 27 ++
 rtl/ysyx_25030077_rd_arbiter.sv | 117 +++++++++++
 tb/tb_ysyx_25030077_rd_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030077_bus_pkg.sv
// Shared read-bus definitions: arbiter states,
// master IDs and AXI response codes.
package ysyx_25030077_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

endpackage

// File: rtl/ysyx_25030077_arb2.sv
// Two-way combinational grant: round-robin
// or fixed LSU priority on ties.
module ysyx_25030077_arb2
  import ysyx_25030077_bus_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = MID_IFU;
    unique case (1'b1)
      req == 2'b11:
        gnt_id = (RR_EN != 0) ? ~last_gnt : MID_LSU;
      req == 2'b10:
        gnt_id = MID_LSU;
      default:
        gnt_id = MID_IFU;
    endcase
  end

endmodule

// File: rtl/ysyx_25030077_rd_arbiter.sv
// Read-channel arbiter: IFU (m0) and LSU (m1)
// share one AR/R port, one transaction in flight.
module ysyx_25030077_rd_arbiter
  import ysyx_25030077_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_ar_valid,
  output logic              m0_ar_ready,
  input  logic [ADDR_W-1:0] m0_ar_addr,
  output logic              m0_r_valid,
  input  logic              m0_r_ready,
  output logic [DATA_W-1:0] m0_r_data,
  output logic [1:0]        m0_r_resp,
  input  logic              m1_ar_valid,
  output logic              m1_ar_ready,
  input  logic [ADDR_W-1:0] m1_ar_addr,
  output logic              m1_r_valid,
  input  logic              m1_r_ready,
  output logic [DATA_W-1:0] m1_r_data,
  output logic [1:0]        m1_r_resp,
  output logic              s_ar_valid,
  input  logic              s_ar_ready,
  output logic [ADDR_W-1:0] s_ar_addr,
  input  logic              s_r_valid,
  output logic              s_r_ready,
  input  logic [DATA_W-1:0] s_r_data,
  input  logic [1:0]        s_r_resp
);

  state_e            state, state_nxt;
  logic              gnt, gnt_nxt;
  logic              last_gnt, last_gnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              gnt_valid;
  logic              gnt_id;
  logic              sel_r_ready;

  ysyx_25030077_arb2 #(
    .RR_EN (RR_EN)
  ) u_arb2 (
    .req       ({m1_ar_valid, m0_ar_valid}),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign sel_r_ready = gnt ? m1_r_ready : m0_r_ready;

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    addr_nxt     = addr_q;
    m0_ar_ready  = 1'b0;
    m1_ar_ready  = 1'b0;
    s_ar_valid   = 1'b0;
    s_r_ready    = 1'b0;
    m0_r_valid   = 1'b0;
    m1_r_valid   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // ar_ready is combinational, so mask it while reset is held
        if (gnt_valid && reset) begin
          m0_ar_ready = (gnt_id == MID_IFU);
          m1_ar_ready = (gnt_id == MID_LSU);
          gnt_nxt     = gnt_id;
          addr_nxt    = gnt_id ? m1_ar_addr : m0_ar_addr;
          state_nxt   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_ar_valid = 1'b1;
        if (s_ar_ready) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        s_r_ready  = sel_r_ready;
        m0_r_valid = ~gnt & s_r_valid;
        m1_r_valid = gnt & s_r_valid;
        if (s_r_valid && sel_r_ready) begin
          state_nxt    = ST_IDLE;
          last_gnt_nxt = gnt;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      gnt      <= MID_IFU;
      last_gnt <= MID_LSU;
      addr_q   <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
      addr_q   <= addr_nxt;
    end
  end

  assign s_ar_addr = addr_q;
  assign m0_r_data = s_r_data;
  assign m1_r_data = s_r_data;
  assign m0_r_resp = s_r_resp;
  assign m1_r_resp = s_r_resp;

endmodule

// File: tb/tb_ysyx_25030077_rd_arbiter.sv
// Bench: round-robin (k=0) and fixed-priority (k=1)
// arbiters driven by shared stimulus, checked by a model.
module tb_ysyx_25030077_rd_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_ar_valid, m1_ar_valid;
  logic [31:0] m0_ar_addr, m1_ar_addr;
  logic        m0_r_ready, m1_r_ready;
  logic        s_ar_ready, s_r_valid;
  logic [31:0] s_r_data;
  logic [1:0]  s_r_resp;

  logic [1:0]  m0_ar_ready, m1_ar_ready;
  logic [1:0]  m0_r_valid, m1_r_valid;
  logic [1:0]  s_ar_valid, s_r_ready;
  logic [31:0] m0_r_data [2];
  logic [31:0] m1_r_data [2];
  logic [31:0] s_ar_addr [2];
  logic [1:0]  m0_r_resp [2];
  logic [1:0]  m1_r_resp [2];

  int total = 0;
  int bad = 0;
  int hs = 0;
  int hs0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    ysyx_25030077_rd_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .RR_EN  ((k == 0) ? 1 : 0)
    ) u_dut (
      .clock       (clk),
      .reset       (rst_n),
      .m0_ar_valid (m0_ar_valid),
      .m0_ar_ready (m0_ar_ready[k]),
      .m0_ar_addr  (m0_ar_addr),
      .m0_r_valid  (m0_r_valid[k]),
      .m0_r_ready  (m0_r_ready),
      .m0_r_data   (m0_r_data[k]),
      .m0_r_resp   (m0_r_resp[k]),
      .m1_ar_valid (m1_ar_valid),
      .m1_ar_ready (m1_ar_ready[k]),
      .m1_ar_addr  (m1_ar_addr),
      .m1_r_valid  (m1_r_valid[k]),
      .m1_r_ready  (m1_r_ready),
      .m1_r_data   (m1_r_data[k]),
      .m1_r_resp   (m1_r_resp[k]),
      .s_ar_valid  (s_ar_valid[k]),
      .s_ar_ready  (s_ar_ready),
      .s_ar_addr   (s_ar_addr[k]),
      .s_r_valid   (s_r_valid),
      .s_r_ready   (s_r_ready[k]),
      .s_r_data    (s_r_data),
      .s_r_resp    (s_r_resp)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int k, input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h exp=%h",
               (k == 0) ? "rr" : "fp", nm, got, exp);
    end
  endtask

  // Transaction-level model: one outstanding read per arbiter
  bit          busy [2];
  bit          sent [2];
  bit          own  [2];
  bit          lg   [2];
  logic [31:0] maddr [2];

  function automatic bit win(input int k);
    if (m0_ar_valid && m1_ar_valid)
      return (k == 0) ? !lg[k] : 1'b1;
    return m1_ar_valid;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        busy[k] = 1'b0;
        sent[k] = 1'b0;
        lg[k]   = 1'b1;
      end else if (!busy[k]) begin
        if (m0_ar_valid || m1_ar_valid) begin
          own[k]   = win(k);
          maddr[k] = own[k] ? m1_ar_addr : m0_ar_addr;
          busy[k]  = 1'b1;
          sent[k]  = 1'b0;
        end
      end else if (!sent[k]) begin
        if (s_ar_ready) sent[k] = 1'b1;
      end else begin
        if (s_r_valid && (own[k] ? m1_r_ready : m0_r_ready)) begin
          busy[k] = 1'b0;
          lg[k]   = own[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_r_valid && s_r_ready[0]) hs++;
    for (int k = 0; k < 2; k++) begin
      logic e0a, e1a, esav, esrr, e0v, e1v;
      e0a = 0; e1a = 0; esav = 0;
      esrr = 0; e0v = 0; e1v = 0;
      if (rst_n) begin
        if (!busy[k]) begin
          if (m0_ar_valid || m1_ar_valid) begin
            e0a = !win(k);
            e1a = win(k);
          end
        end else if (!sent[k]) begin
          esav = 1'b1;
        end else begin
          esrr = own[k] ? m1_r_ready : m0_r_ready;
          e0v  = !own[k] && s_r_valid;
          e1v  = own[k] && s_r_valid;
        end
      end
      chk(k, "m0_ar_ready", {31'd0, m0_ar_ready[k]}, {31'd0, e0a});
      chk(k, "m1_ar_ready", {31'd0, m1_ar_ready[k]}, {31'd0, e1a});
      chk(k, "s_ar_valid", {31'd0, s_ar_valid[k]}, {31'd0, esav});
      chk(k, "s_r_ready", {31'd0, s_r_ready[k]}, {31'd0, esrr});
      chk(k, "m0_r_valid", {31'd0, m0_r_valid[k]}, {31'd0, e0v});
      chk(k, "m1_r_valid", {31'd0, m1_r_valid[k]}, {31'd0, e1v});
      if (esav) chk(k, "s_ar_addr", s_ar_addr[k], maddr[k]);
      if (e0v) begin
        chk(k, "m0_r_data", m0_r_data[k], s_r_data);
        chk(k, "m0_r_resp", {30'd0, m0_r_resp[k]}, {30'd0, s_r_resp});
      end
      if (e1v) begin
        chk(k, "m1_r_data", m1_r_data[k], s_r_data);
        chk(k, "m1_r_resp", {30'd0, m1_r_resp[k]}, {30'd0, s_r_resp});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    m0_ar_valid = 1; m1_ar_valid = 0;
    m0_ar_addr = 0; m1_ar_addr = 0;
    m0_r_ready = 0; m1_r_ready = 0;
    s_ar_ready = 0; s_r_valid = 0;
    s_r_data = 0; s_r_resp = 0;
    repeat (2) @(negedge clk);
    chk(0, "rst_m0_ar_ready", {31'd0, m0_ar_ready[0]}, 0);
    chk(0, "rst_s_ar_valid", {31'd0, s_ar_valid[0]}, 0);
    step();
    rst_n = 1;
    m0_ar_valid = 0;

    // IFU alone, zero-wait slave
    step();
    m0_ar_valid = 1; m0_ar_addr = 32'h8000_0000;
    s_ar_ready = 1; s_r_valid = 1; s_r_data = 32'h0000_0413;
    m0_r_ready = 1; m1_r_ready = 1;
    @(negedge clk);
    chk(0, "t1_m0_ar_ready", {31'd0, m0_ar_ready[0]}, 1);
    step();
    m0_ar_valid = 0;
    @(negedge clk);
    chk(0, "t1_s_ar_valid", {31'd0, s_ar_valid[0]}, 1);
    chk(0, "t1_s_ar_addr", s_ar_addr[0], 32'h8000_0000);
    step();
    @(negedge clk);
    chk(0, "t1_m0_r_valid", {31'd0, m0_r_valid[0]}, 1);
    chk(0, "t1_m0_r_data", m0_r_data[0], 32'h0000_0413);
    chk(0, "t1_m1_r_valid", {31'd0, m1_r_valid[0]}, 0);
    step();
    @(negedge clk);
    chk(0, "t1_idle", {31'd0, s_ar_valid[0]}, 0);

    // ties after reset: rr alternates from m0, fp always m1
    step(); rst_n = 0;
    step(); rst_n = 1;
    m0_ar_valid = 1; m0_ar_addr = 32'h8000_0004;
    m1_ar_valid = 1; m1_ar_addr = 32'h8000_1000;
    for (int c = 0; c < 10; c++) begin
      if (c == 9) m1_ar_valid = 0;
      @(negedge clk);
      chk(0, "tie_m0_ar_ready", {31'd0, m0_ar_ready[0]},
          {31'd0, (c == 0 || c == 6 || c == 9)});
      chk(0, "tie_m1_ar_ready", {31'd0, m1_ar_ready[0]},
          {31'd0, (c == 3)});
      chk(1, "tie_m0_ar_ready", {31'd0, m0_ar_ready[1]},
          {31'd0, (c == 9)});
      chk(1, "tie_m1_ar_ready", {31'd0, m1_ar_ready[1]},
          {31'd0, (c == 0 || c == 3 || c == 6)});
      if (c == 1) begin
        chk(0, "tie_addr1", s_ar_addr[0], 32'h8000_0004);
        chk(1, "tie_addr1", s_ar_addr[1], 32'h8000_1000);
      end
      if (c == 4) chk(0, "tie_addr2", s_ar_addr[0], 32'h8000_1000);
      step();
    end
    m0_ar_valid = 0;
    repeat (2) step();

    // backpressure on AR then on R
    s_ar_ready = 0;
    m1_ar_valid = 1; m1_ar_addr = 32'h8000_2000;
    m1_r_ready = 0;
    hs0 = hs;
    @(negedge clk);
    chk(0, "bp_m1_ar_ready", {31'd0, m1_ar_ready[0]}, 1);
    step();
    m1_ar_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(0, "bp_s_ar_valid", {31'd0, s_ar_valid[0]}, 1);
      chk(0, "bp_s_ar_addr", s_ar_addr[0], 32'h8000_2000);
      step();
    end
    s_ar_ready = 1;
    @(negedge clk);
    chk(0, "bp_s_ar_valid4", {31'd0, s_ar_valid[0]}, 1);
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk(0, "bp_s_r_ready0", {31'd0, s_r_ready[0]}, 0);
      chk(0, "bp_m1_r_valid", {31'd0, m1_r_valid[0]}, 1);
      step();
    end
    m1_r_ready = 1;
    @(negedge clk);
    chk(0, "bp_s_r_ready1", {31'd0, s_r_ready[0]}, 1);
    step();
    @(negedge clk);
    chk(0, "bp_idle_sav", {31'd0, s_ar_valid[0]}, 0);
    chk(0, "bp_idle_rv", {31'd0, m1_r_valid[0]}, 0);
    chk(0, "bp_handshakes", hs - hs0, 1);

    // SLVERR passes through, no retry
    step();
    m0_ar_valid = 1; m0_ar_addr = 32'h8000_0008;
    s_r_resp = 2'd2; s_r_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk(0, "err_m0_ar_ready", {31'd0, m0_ar_ready[0]}, 1);
    step();
    m0_ar_valid = 0;
    step();
    @(negedge clk);
    chk(0, "err_m0_r_valid", {31'd0, m0_r_valid[0]}, 1);
    chk(0, "err_m0_r_resp", {30'd0, m0_r_resp[0]}, 2);
    chk(0, "err_m0_r_data", m0_r_data[0], 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    chk(0, "err_no_retry", {31'd0, s_ar_valid[0]}, 0);
    chk(0, "err_idle_srr", {31'd0, s_r_ready[0]}, 0);
    s_r_resp = 0;

    // reset while a beat is pending in DATA
    step();
    m0_ar_valid = 1; m0_ar_addr = 32'h8000_000C;
    m0_r_ready = 0;
    step();
    m0_ar_valid = 0;
    step();
    @(negedge clk);
    chk(0, "rd_m0_r_valid", {31'd0, m0_r_valid[0]}, 1);
    #2 rst_n = 0;
    #1;
    chk(0, "rd_async_rv", {31'd0, m0_r_valid[0]}, 0);
    chk(0, "rd_async_srr", {31'd0, s_r_ready[0]}, 0);
    chk(0, "rd_async_sav", {31'd0, s_ar_valid[0]}, 0);
    step();
    step();
    rst_n = 1;
    m0_r_ready = 1;
    m0_ar_valid = 1; m0_ar_addr = 32'h8000_0010;
    m1_ar_valid = 1; m1_ar_addr = 32'h8000_1004;
    @(negedge clk);
    chk(0, "rd_m0_ar_ready", {31'd0, m0_ar_ready[0]}, 1);
    chk(0, "rd_m1_ar_ready", {31'd0, m1_ar_ready[0]}, 0);
    chk(1, "rd_m1_ar_ready", {31'd0, m1_ar_ready[1]}, 1);
    step();
    m0_ar_valid = 0; m1_ar_valid = 0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
